// File: rtl/tlk2711_pkg.sv
// tlk2711_pkg: symbol words, mode encodings, FSM states and the PRBS15 step function.
// These definitions are shared by the TLK2711 transmit generator and receive checker.
package tlk2711_pkg;

  localparam logic [15:0] IDLE_WORD  = 16'hC5BC;
  localparam logic [15:0] SOF_WORD   = 16'h50FB;
  localparam logic [15:0] EOF_WORD   = 16'h50FD;
  localparam logic [15:0] ERR_WORD   = 16'hFFFF;
  localparam logic [15:0] FIXED_WORD = 16'hA55A;
  localparam logic [14:0] PRBS_SEED  = 15'h7FFF;

  typedef enum logic [2:0] {
    MODE_RAMP  = 3'd0,
    MODE_FIXED = 3'd1,
    MODE_PRBS  = 3'd2
  } mode_e;

  typedef enum logic [1:0] {
    UNSYNC  = 2'd0,
    LINK    = 2'd1,
    PAYLOAD = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    SYM_IDLE,
    SYM_SOF,
    SYM_EOF,
    SYM_ERR,
    SYM_DATA,
    SYM_BAD
  } sym_e;

  typedef struct packed {
    logic [14:0] state;
    logic [15:0] word;
  } prbs_step_t;

  // Control symbols carry their K-flag on the LSB byte only; ERR has both flags set.
  function automatic sym_e classify(input logic [15:0] d, input logic kmsb, input logic klsb);
    sym_e s;
    s = SYM_BAD;
    if (kmsb && klsb && d == ERR_WORD) s = SYM_ERR;
    else if (!kmsb && !klsb)           s = SYM_DATA;
    else if (klsb && !kmsb) begin
      case (d)
        IDLE_WORD: s = SYM_IDLE;
        SOF_WORD:  s = SYM_SOF;
        EOF_WORD:  s = SYM_EOF;
        default:   s = SYM_BAD;
      endcase
    end
    return s;
  endfunction

  // x^15+x^14+1, 16 bits per word, first generated bit lands in the MSB.
  function automatic prbs_step_t prbs15_step16(input logic [14:0] seed);
    prbs_step_t  r;
    logic [14:0] s;
    logic        fb;
    s      = seed;
    r.word = '0;
    for (int i = 15; i >= 0; i--) begin
      fb        = s[14] ^ s[13];
      r.word[i] = fb;
      s         = {s[13:0], fb};
    end
    r.state = s;
    return r;
  endfunction

endpackage

// File: rtl/tlk2711_prbs15.sv
// tlk2711_prbs15: PRBS15 word source, reseeded to all-ones on load, advanced 16 bits per word.
// Only instantiated when TLK2711_RX_PRBS_EN is defined.
module tlk2711_prbs15
  import tlk2711_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        advance,
  output logic [15:0] word
);

  logic [14:0] state;
  prbs_step_t  step;

  always_comb step = prbs15_step16(state);
  assign word = step.word;

  always_ff @(posedge clk) begin
    if (rst || load)  state <= PRBS_SEED;
    else if (advance) state <= step.state;
  end

endmodule

// File: rtl/tlk2711_rx_checker.sv
// tlk2711_rx_checker: TLK2711 RX link sync, frame delimiting, payload check and statistics.
// Define TLK2711_RX_PRBS_EN to build PRBS15 checking for mode 2 (otherwise mode 2 = ramp).
module tlk2711_rx_checker
  import tlk2711_pkg::*;
#(
  parameter int PAYLOAD_LEN = 256,
  parameter int LOCK_CNT    = 16,
  parameter int LOSS_CNT    = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      i_rxd,
  input  logic             i_rkmsb,
  input  logic             i_rklsb,
  input  logic [2:0]       i_mode,
  input  logic             i_clr,
  output logic             o_link_up,
  output logic             o_frame_done,
  output logic             o_frame_err,
  output logic [CNT_W-1:0] o_frame_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_code_err
);

  localparam int WC_W = $clog2(PAYLOAD_LEN + 2);
  localparam int LK_W = $clog2(LOCK_CNT + 1);
  localparam int LS_W = $clog2(LOSS_CNT + 1);
  localparam logic [WC_W-1:0] WC_LEN   = WC_W'(PAYLOAD_LEN);
  localparam logic [WC_W-1:0] WC_SAT   = WC_W'(PAYLOAD_LEN + 1);
  localparam logic [LK_W-1:0] LOCK_TOP = LK_W'(LOCK_CNT - 1);
  localparam logic [LS_W-1:0] LOSS_TOP = LS_W'(LOSS_CNT - 1);

  logic [15:0] rxd_q;
  logic        rkmsb_q, rklsb_q, clr_q;
  logic [2:0]  mode_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_q   <= '0;
      rkmsb_q <= 1'b0;
      rklsb_q <= 1'b0;
      clr_q   <= 1'b0;
      mode_q  <= '0;
    end else begin
      rxd_q   <= i_rxd;
      rkmsb_q <= i_rkmsb;
      rklsb_q <= i_rklsb;
      clr_q   <= i_clr;
      mode_q  <= i_mode;
    end
  end

  sym_e   sym;
  state_e state, state_next;
  mode_e  frame_mode, mode_sel;

  logic [LK_W-1:0] idle_cnt;
  logic [LS_W-1:0] inv_cnt;
  logic [WC_W-1:0] word_cnt;
  logic [15:0]     ramp, expect_word;
  logic            frame_flag;

  logic invalid, in_frame, data_word, mismatch, len_err;
  logic frame_close, close_err, err_inc, load_seed, flag_set;

  always_comb sym = classify(rxd_q, rkmsb_q, rklsb_q);

  always_comb begin
    case (mode_q)
      3'd1:    mode_sel = MODE_FIXED;
`ifdef TLK2711_RX_PRBS_EN
      3'd2:    mode_sel = MODE_PRBS;
`endif
      default: mode_sel = MODE_RAMP;
    endcase
  end

`ifdef TLK2711_RX_PRBS_EN
  logic [15:0] prbs_word;

  tlk2711_prbs15 u_prbs (
    .clk     (clk),
    .rst     (rst),
    .load    (load_seed),
    .advance (data_word),
    .word    (prbs_word)
  );
`endif

  always_comb begin
    case (frame_mode)
      MODE_FIXED: expect_word = FIXED_WORD;
`ifdef TLK2711_RX_PRBS_EN
      MODE_PRBS:  expect_word = prbs_word;
`endif
      default:    expect_word = ramp;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= UNSYNC;
    else     state <= state_next;
  end

  // FSM next state; an ERR word overrides every other transition
  always_comb begin
    state_next = state;
    case (state)
      UNSYNC:  if (sym == SYM_IDLE && idle_cnt == LOCK_TOP) state_next = LINK;
      LINK: begin
        if (sym == SYM_SOF)                       state_next = PAYLOAD;
        else if (invalid && inv_cnt == LOSS_TOP)  state_next = UNSYNC;
      end
      PAYLOAD: begin
        if (sym == SYM_EOF)                       state_next = LINK;
        else if (invalid && inv_cnt == LOSS_TOP)  state_next = UNSYNC;
      end
      default: state_next = UNSYNC;
    endcase
    if (sym == SYM_ERR) state_next = UNSYNC;
  end

  // FSM outputs: per-word actions for the datapath and statistics
  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    invalid     = 1'b0;
    in_frame    = (state == PAYLOAD);
    case (state)
      LINK:    invalid = (sym == SYM_DATA) || (sym == SYM_EOF) || (sym == SYM_BAD);
      PAYLOAD: invalid = (sym == SYM_BAD);
      default: invalid = 1'b0;
    endcase
    load_seed   = (state != UNSYNC) && (sym == SYM_SOF);
    data_word   = in_frame && (sym == SYM_DATA);
    mismatch    = data_word && (rxd_q != expect_word);
    len_err     = in_frame && (sym == SYM_EOF) && (word_cnt != WC_LEN);
    frame_close = in_frame && ((sym == SYM_EOF) || (sym == SYM_SOF));
    close_err   = frame_flag || len_err || (sym == SYM_SOF);
    flag_set    = mismatch || (in_frame && sym == SYM_IDLE);
    err_inc     = flag_set || len_err || (in_frame && sym == SYM_SOF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt     <= '0;
      inv_cnt      <= '0;
      word_cnt     <= '0;
      ramp         <= '0;
      frame_flag   <= 1'b0;
      frame_mode   <= MODE_RAMP;
      o_link_up    <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
      o_frame_cnt  <= '0;
      o_err_cnt    <= '0;
      o_code_err   <= 1'b0;
    end else begin
      if (state == UNSYNC && sym == SYM_IDLE && state_next == UNSYNC)
        idle_cnt <= idle_cnt + LK_W'(1);
      else
        idle_cnt <= '0;

      if (invalid && state_next != UNSYNC) inv_cnt <= inv_cnt + LS_W'(1);
      else                                 inv_cnt <= '0;

      if (load_seed) begin
        word_cnt   <= '0;
        ramp       <= '0;
        frame_flag <= 1'b0;
        frame_mode <= mode_sel;
      end else begin
        if (data_word) ramp <= ramp + 16'd1;
        if (data_word && word_cnt != WC_SAT) word_cnt <= word_cnt + WC_W'(1);
        if (flag_set) frame_flag <= 1'b1;
      end

      o_link_up    <= (state_next != UNSYNC);
      o_frame_done <= frame_close;
      o_frame_err  <= frame_close && close_err;

      // A clear pulse beats a coincident increment.
      if (clr_q)                                     o_frame_cnt <= '0;
      else if (frame_close && o_frame_cnt != '1)     o_frame_cnt <= o_frame_cnt + CNT_W'(1);

      if (clr_q)                                     o_err_cnt <= '0;
      else if (err_inc && o_err_cnt != '1)           o_err_cnt <= o_err_cnt + CNT_W'(1);

      if (sym == SYM_ERR)                            o_code_err <= 1'b1;
      else if (clr_q)                                o_code_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tlk2711_rx_checker.sv
// tb_tlk2711_rx_checker: directed self-checking bench for tlk2711_rx_checker (CNT_W=4 build).
// PRBS frames are exercised only when TLK2711_RX_PRBS_EN is defined.
module tb_tlk2711_rx_checker;
  import tlk2711_pkg::*;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [15:0]      i_rxd;
  logic             i_rkmsb, i_rklsb, i_clr;
  logic [2:0]       i_mode;
  logic             o_link_up, o_frame_done, o_frame_err, o_code_err;
  logic [CNT_W-1:0] o_frame_cnt, o_err_cnt;

  int n_assert  = 0;
  int n_fail    = 0;
  int done_seen = 0;
  int ferr_seen = 0;
  logic clr_pend = 1'b0;

  tlk2711_rx_checker #(
    .PAYLOAD_LEN (256),
    .LOCK_CNT    (16),
    .LOSS_CNT    (4),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rxd        (i_rxd),
    .i_rkmsb      (i_rkmsb),
    .i_rklsb      (i_rklsb),
    .i_mode       (i_mode),
    .i_clr        (i_clr),
    .o_link_up    (o_link_up),
    .o_frame_done (o_frame_done),
    .o_frame_err  (o_frame_err),
    .o_frame_cnt  (o_frame_cnt),
    .o_err_cnt    (o_err_cnt),
    .o_code_err   (o_code_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (o_frame_done) done_seen++;
      if (o_frame_err)  ferr_seen++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] w, input logic km, input logic kl);
    @(negedge clk);
    i_rxd   = w;
    i_rkmsb = km;
    i_rklsb = kl;
    i_clr   = clr_pend;
    clr_pend = 1'b0;
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) send(IDLE_WORD, 1'b0, 1'b1);
  endtask

  task automatic send_sof();
    send(SOF_WORD, 1'b0, 1'b1);
  endtask

  task automatic send_eof();
    send(EOF_WORD, 1'b0, 1'b1);
  endtask

  task automatic send_data(input logic [15:0] w);
    send(w, 1'b0, 1'b0);
  endtask

  task automatic send_ramp(input int first, input int n);
    for (int i = 0; i < n; i++) send_data(16'(first + i));
  endtask

  // Idle words let the two-cycle pipeline drain before outputs are compared.
  task automatic flush();
    send_idle(3);
    #1;
  endtask

  task automatic check_stats(input string tag, input int fc, input int ec, input int dn, input int fe);
    check({tag, " frame_cnt"}, 32'(o_frame_cnt), 32'(fc));
    check({tag, " err_cnt"},   32'(o_err_cnt),   32'(ec));
    check({tag, " done"},      32'(done_seen),   32'(dn));
    check({tag, " frame_err"}, 32'(ferr_seen),   32'(fe));
  endtask

`ifdef TLK2711_RX_PRBS_EN
  task automatic prbs_frame(input int flip_idx);
    logic [14:0] s;
    logic [15:0] w;
    logic        fb;
    s = 15'h7FFF;
    send_sof();
    for (int k = 0; k < 256; k++) begin
      for (int b = 15; b >= 0; b--) begin
        fb   = s[14] ^ s[13];
        w[b] = fb;
        s    = {s[13:0], fb};
      end
      if (k == flip_idx) w[0] = ~w[0];
      send_data(w);
    end
    send_eof();
    flush();
  endtask
`endif

  initial begin
    rst = 1'b1; i_rxd = '0; i_rkmsb = 1'b0; i_rklsb = 1'b0; i_mode = 3'd0; i_clr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset link_up",   32'(o_link_up),    32'd0);
    check("reset done",      32'(o_frame_done), 32'd0);
    check("reset frame_err", 32'(o_frame_err),  32'd0);
    check("reset frame_cnt", 32'(o_frame_cnt),  32'd0);
    check("reset err_cnt",   32'(o_err_cnt),    32'd0);
    check("reset code_err",  32'(o_code_err),   32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 15 idles broken by a data word must not lock, twice over.
    send_idle(15);
    send_data(16'h1234);
    send_idle(15);
    send_data(16'h1234);
    repeat (3) @(negedge clk);
    #1;
    check("no lock 15+1", 32'(o_link_up), 32'd0);

    // Sixteenth idle: link_up rises exactly two cycles later.
    send_idle(16);
    @(negedge clk);
    check("lock latency-1", 32'(o_link_up), 32'd0);
    @(negedge clk);
    check("lock latency-2", 32'(o_link_up), 32'd1);
    flush();

    // Clean ramp frame.
    send_sof(); send_ramp(0, 256); send_eof(); flush();
    check_stats("ramp ok", 1, 0, 1, 0);

    // Word 10 corrupted.
    send_sof(); send_ramp(0, 10); send_data(16'hDEAD); send_ramp(11, 245); send_eof(); flush();
    check_stats("mismatch", 2, 1, 2, 1);

    // Short frame: 255 words.
    send_sof(); send_ramp(0, 255); send_eof(); flush();
    check_stats("short", 3, 2, 3, 2);

    // Fixed pattern; the mode change after SOF must not affect this frame.
    i_mode = 3'd1;
    send_sof(); send_data(FIXED_WORD); i_mode = 3'd0;
    for (int i = 0; i < 255; i++) send_data(FIXED_WORD);
    send_eof(); flush();
    check_stats("fixed", 4, 2, 4, 2);

    // SOF inside a frame aborts it as errored, then a clean frame follows.
    send_sof(); send_ramp(0, 5); send_sof(); send_ramp(0, 256); send_eof(); flush();
    check_stats("abort", 6, 3, 6, 3);

    // IDLE inside a frame counts an error but does not advance the ramp.
    send_sof(); send_ramp(0, 100); send_idle(1); send_ramp(100, 156); send_eof(); flush();
    check_stats("idle in frame", 7, 4, 7, 4);

    // Three stray data words then idle: link holds; four drop it.
    send_ramp(0, 3); flush();
    check("3 invalid keep", 32'(o_link_up), 32'd1);
    send_ramp(0, 4); flush();
    check("4 invalid drop", 32'(o_link_up), 32'd0);
    send_idle(16); flush();
    check("relock 1", 32'(o_link_up), 32'd1);

    // Code error mid-frame: frame discarded, no done pulse.
    send_sof(); send_ramp(0, 20); send(ERR_WORD, 1'b1, 1'b1); flush();
    check("err word link",     32'(o_link_up),  32'd0);
    check("err word code_err", 32'(o_code_err), 32'd1);
    check_stats("err word", 7, 4, 7, 4);

    clr_pend = 1'b1; send_idle(1); flush();
    check("clr code_err", 32'(o_code_err), 32'd0);
    check_stats("clr", 0, 0, 7, 4);

    send_idle(16); flush();
    check("relock 2", 32'(o_link_up), 32'd1);

    // 20 mismatches plus a length error saturate the 4-bit counter.
    send_sof();
    for (int i = 0; i < 20; i++) send_data(16'hDEAD);
    send_eof(); flush();
    check_stats("saturate", 1, 15, 8, 5);

    // Clear coincident with a mismatch: clear wins, frame length is correct.
    send_sof(); send_ramp(0, 255); clr_pend = 1'b1; send_data(16'hDEAD); send_eof(); flush();
    check_stats("clr wins", 1, 0, 9, 6);

`ifdef TLK2711_RX_PRBS_EN
    i_mode = 3'd2;
    prbs_frame(-1);
    check_stats("prbs ok", 2, 0, 10, 6);
    prbs_frame(50);
    check_stats("prbs flip", 3, 1, 11, 7);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
